// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 Hz timing constants and coordinate helpers
package vga_pkg;
  localparam int COORD_W = 10;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  localparam logic SYNC_ACTIVE = 1'b0;
  typedef logic [COORD_W-1:0] coord_t;
  function automatic logic inRange(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter 0..TOTAL-1 advancing on inc, flags the wrap cycle
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic   clock25MHz,
  input  logic   reset,
  input  logic   inc,
  output logic   wrap,
  output coord_t count
);
  if (TOTAL < 2 || TOTAL > 1024) begin : gBadTotal
    $error("vga_axis_counter: TOTAL out of range for a 10-bit counter");
  end
  assign wrap = inc && (count == COORD_W'(TOTAL - 1));
  // advance on inc, returning to zero on the same cycle the wrap flag is raised
  always_ff @(posedge clock25MHz)
    if (reset) count <= '0;
    else if (inc) count <= wrap ? '0 : count + COORD_W'(1);
endmodule

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: VGA raster timing, coordinate publish and blanked, sync-aligned pin stage
module vga_timing_driver #(
  parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic       clock25MHz,
  input  logic       reset,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frameStart,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       hsync,
  output logic       vsync
);
  import vga_pkg::*;
  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_START + V_SYNC;
  coord_t hCount, vCount;
  logic hWrap;
  vga_axis_counter #(.TOTAL(HT)) hCounter (
    .clock25MHz(clock25MHz), .reset(reset), .inc(1'b1), .wrap(hWrap), .count(hCount)
  );
  vga_axis_counter #(.TOTAL(VT)) vCounter (
    .clock25MHz(clock25MHz), .reset(reset), .inc(hWrap), .wrap(), .count(vCount)
  );
  assign x = hCount;
  assign y = vCount;
  assign active = inRange(hCount, 0, H_VISIBLE) && inRange(vCount, 0, V_VISIBLE);
  assign frameStart = !reset && hCount == '0 && vCount == '0;
  // single pin bank so colour and both syncs change on the same edge
  always_ff @(posedge clock25MHz)
    if (reset) begin
      vgaRed <= '0;
      vgaGreen <= '0;
      vgaBlue <= '0;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
    end else begin
      vgaRed <= active ? red : '0;
      vgaGreen <= active ? green : '0;
      vgaBlue <= active ? blue : '0;
      hsync <= inRange(hCount, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= inRange(vCount, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
endmodule

// File: tb/tb_vga_timing_driver.sv
// tb_vga_timing_driver: directed checks of raster timing, blanking, echo and reset
module tb_vga_timing_driver;
  logic clk = 1'b0;
  logic rst = 1'b1, rstS = 1'b1, echo = 1'b0;
  logic [3:0] colour = 4'hF;
  logic [3:0] red, green, blue, vgaRed, vgaGreen, vgaBlue;
  logic [9:0] x, y;
  logic active, frameStart, hsync, vsync;
  logic [3:0] sCol, sRed, sGreen, sBlue;
  logic [9:0] sx, sy;
  logic sActive, sFrameStart, sHsync, sVsync;
  int tests = 0, fails = 0;
  int hLow, firstLow, lastLow, vLow, firstVLow, fsCount, firstFs, prev, px, py;
  logic [3:0] e;

  always #20 clk = ~clk;
  assign red = echo ? x[3:0] : colour;
  assign green = echo ? x[3:0] : colour;
  assign blue = echo ? x[3:0] : colour;
  assign sCol = sx[3:0];

  vga_timing_driver dut (
    .clock25MHz(clk), .reset(rst), .red(red), .green(green), .blue(blue),
    .x(x), .y(y), .active(active), .frameStart(frameStart),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .hsync(hsync), .vsync(vsync)
  );

  // reduced raster: 15 cycles per line, 10 lines per frame, so whole frames fit the run
  vga_timing_driver #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b0)
  ) dutSmall (
    .clock25MHz(clk), .reset(rstS), .red(sCol), .green(sCol), .blue(sCol),
    .x(sx), .y(sy), .active(sActive), .frameStart(sFrameStart),
    .vgaRed(sRed), .vgaGreen(sGreen), .vgaBlue(sBlue), .hsync(sHsync), .vsync(sVsync)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    tick(10);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_red", vgaRed, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_fs", frameStart, 0);
    rst = 1'b0;
    echo = 1'b1;
    #1;
    check("rel_fs", frameStart, 1);
    check("rel_x", x, 0);
    check("rel_y", y, 0);
    check("rel_pin", {vgaRed, vgaGreen, vgaBlue}, 0);
    hLow = 0; firstLow = -1; lastLow = -1;
    for (int k = 1; k <= 800; k++) begin
      tick(1);
      prev = k - 1;
      e = (prev < 640) ? 4'(prev % 16) : 4'h0;
      check("line_x", x, k % 800);
      check("line_y", y, k / 800);
      check("line_fs", frameStart, 0);
      check("line_echo", {vgaRed, vgaGreen, vgaBlue}, {e, e, e});
      check("line_hsync", hsync, (prev >= 656 && prev < 752) ? 0 : 1);
      check("line_vsync", vsync, 1);
      if (hsync === 1'b0) begin
        hLow++;
        if (firstLow < 0) firstLow = k;
        lastLow = k;
      end
    end
    check("hsync_low_count", hLow, 96);
    check("hsync_first_low", firstLow, 657);
    check("hsync_last_low", lastLow, 752);
    echo = 1'b0;
    colour = 4'hF;
    tick(639);
    check("blank_at639_x", x, 639);
    tick(1);
    check("blank_pin639", {vgaRed, vgaGreen, vgaBlue}, 12'hFFF);
    tick(1);
    check("blank_pin640", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    colour = 4'h5;
    tick(50);
    check("blank_change", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    tick(409);
    check("mid_x", x, 300);
    check("mid_y", y, 2);
    check("mid_pin", {vgaRed, vgaGreen, vgaBlue}, 12'h555);
    rst = 1'b1;
    tick(1);
    check("mrst_x", x, 0);
    check("mrst_y", y, 0);
    check("mrst_pin", {vgaRed, vgaGreen, vgaBlue}, 0);
    check("mrst_hsync", hsync, 1);
    check("mrst_fs", frameStart, 0);
    rst = 1'b0;
    #1;
    check("mrel_fs", frameStart, 1);
    tick(1);
    check("mrel_pin", {vgaRed, vgaGreen, vgaBlue}, 12'h555);
    tick(655);
    check("mrel_hs656", hsync, 1);
    tick(1);
    check("mrel_hs657", hsync, 0);
    tick(95);
    check("mrel_hs752", hsync, 0);
    tick(1);
    check("mrel_hs753", hsync, 1);
    check("small_rst_fs", sFrameStart, 0);
    check("small_rst_vsync", sVsync, 1);
    rstS = 1'b0;
    #1;
    check("small_rel_fs", sFrameStart, 1);
    vLow = 0; firstVLow = -1; fsCount = 0; firstFs = -1;
    for (int c = 1; c <= 300; c++) begin
      tick(1);
      px = (c - 1) % 15;
      py = ((c - 1) / 15) % 10;
      e = (px < 8 && py < 6) ? 4'(px) : 4'h0;
      check("sm_x", sx, c % 15);
      check("sm_y", sy, (c / 15) % 10);
      check("sm_fs", sFrameStart, (c % 150 == 0) ? 1 : 0);
      check("sm_pin", {sRed, sGreen, sBlue}, {e, e, e});
      check("sm_hsync", sHsync, (px >= 10 && px < 13) ? 0 : 1);
      check("sm_vsync", sVsync, (py >= 7 && py < 9) ? 0 : 1);
      if (c <= 150 && sVsync === 1'b0) begin
        vLow++;
        if (firstVLow < 0) firstVLow = c;
      end
      if (sFrameStart === 1'b1) begin
        fsCount++;
        if (firstFs < 0) firstFs = c;
      end
    end
    check("sm_vlow_count", vLow, 30);
    check("sm_vlow_first", firstVLow, 106);
    check("sm_fs_count", fsCount, 2);
    check("sm_fs_first", firstFs, 150);
    tick(65);
    check("sm_mid_x", sx, 5);
    check("sm_mid_y", sy, 4);
    rstS = 1'b1;
    tick(1);
    check("sm_mrst_x", sx, 0);
    check("sm_mrst_y", sy, 0);
    check("sm_mrst_pin", {sRed, sGreen, sBlue}, 0);
    check("sm_mrst_sync", {sHsync, sVsync}, 2'b11);
    tick(3);
    check("sm_hold_xy", {sx, sy}, 0);
    check("sm_hold_fs", sFrameStart, 0);
    rstS = 1'b0;
    #1;
    check("sm_mrel_fs", sFrameStart, 1);
    fsCount = 0; firstFs = -1; vLow = 0; firstVLow = -1;
    for (int c = 1; c <= 150; c++) begin
      tick(1);
      if (sFrameStart === 1'b1) begin
        fsCount++;
        if (firstFs < 0) firstFs = c;
      end
      if (sVsync === 1'b0) begin
        vLow++;
        if (firstVLow < 0) firstVLow = c;
      end
    end
    check("sm_post_fs_count", fsCount, 1);
    check("sm_post_fs_first", firstFs, 150);
    check("sm_post_vlow", vLow, 30);
    check("sm_post_vfirst", firstVLow, 106);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
